// File: rtl/inst_queue.sv
// inst_queue: Fetch -> Decode instruction queue.
// A one-stage capture register (S1) aligns each Fetch request with the
// synchronous inst_sram read data that returns in the following cycle. The
// combined entry is pushed into a DEPTH-entry FIFO, and the FIFO head is
// presented to Decode.
// Optional feature: define INST_QUEUE_BYPASS_EN to forward the S1 entry
// straight to Decode when the FIFO is empty. This saves one cycle of latency.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             FD_valid,
  input  logic [42:0]      FD_BUS,
  input  logic [31:0]      inst_sram_rdata,
  output logic             Q_allowin,
  input  logic             D_allowin,
  output logic             QD_valid,
  output logic [73:0]      QD_BUS,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [73:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  // S1 capture of the accepted request; the read data arrives one cycle later
  logic        s1_valid;
  logic [31:0] s1_pc;
  logic        s1_ex;
  logic [7:0]  s1_ecode;
  logic        s1_esub;

  logic        accept, push, pop, nonempty;
  logic [73:0] s1_entry;
  logic [CNT_W:0] occ;

  // An address-fault request returns no valid data, so its word is forced to zero
  assign s1_entry = {s1_pc, (s1_ex ? 32'h0 : inst_sram_rdata), s1_ex, s1_ecode, s1_esub};

  // Backpressure counts the in-flight S1 slot so that no push can overflow.
  // It depends only on local state, so Decode has no combinational path to Fetch.
  assign occ       = {1'b0, count} + {{CNT_W{1'b0}}, s1_valid};
  assign Q_allowin = flush || (occ <= (CNT_W+1)'(DEPTH - 1));
  assign accept    = FD_valid && FD_BUS[10] && Q_allowin;
  assign nonempty  = (count != '0);
  assign pop       = nonempty && !flush && D_allowin;

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass   = !nonempty && s1_valid && !flush;
  // A bypassed entry that Decode takes in the same cycle never enters the FIFO
  assign push     = s1_valid && !flush && !(bypass && D_allowin);
  assign QD_valid = (nonempty && !flush) || bypass;
  assign QD_BUS   = bypass ? s1_entry : mem[rd_ptr];
`else
  assign push     = s1_valid && !flush;
  assign QD_valid = nonempty && !flush;
  assign QD_BUS   = mem[rd_ptr];
`endif

  // S1 capture: a request that arrives during a flush is the redirect target and is kept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_ex    <= 1'b0;
      s1_ecode <= '0;
      s1_esub  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pc    <= FD_BUS[42:11];
        s1_ex    <= FD_BUS[9];
        s1_ecode <= FD_BUS[8:1];
        s1_esub  <= FD_BUS[0];
      end
    end
  end

  // FIFO storage: the write port takes the S1 entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= s1_entry;
    end
  end

  // Pointers and occupancy: a flush drops everything older than the redirect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: self-checking bench for inst_queue.
// It applies a table of streaming vectors, then directed corner sequences,
// then randomized traffic. Every cycle is checked against a queue-based
// reference model. INST_QUEUE_BYPASS_EN selects the bypass timing.
module tb_inst_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk, rstn, flush, FD_valid, D_allowin;
  logic [42:0]      FD_BUS;
  logic [31:0]      inst_sram_rdata;
  logic             Q_allowin, QD_valid;
  logic [73:0]      QD_BUS;
  logic [CNT_W-1:0] count;

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .FD_valid(FD_valid), .FD_BUS(FD_BUS),
    .inst_sram_rdata(inst_sram_rdata), .Q_allowin(Q_allowin), .D_allowin(D_allowin),
    .QD_valid(QD_valid), .QD_BUS(QD_BUS), .count(count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rstn) assert (count <= DEPTH) else $error("FAIL overflow: count %0d above %0d", count, DEPTH);

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [7:0]  ecode;
    logic        esub;
  } ent_t;

  ent_t mq[$];
  ent_t m_s1;
  bit   m_s1v;
  bit   m_allow, m_qv;
  logic [73:0] m_bus;

  int vecs = 0, errs = 0;
  bit last_pop;
  logic [31:0] last_pop_pc;
  bit rd_force_en = 0;
  logic [31:0] rd_force = '0;

  function automatic logic [73:0] pk(ent_t e);
    return {e.pc, e.inst, e.ex, e.ecode, e.esub};
  endfunction

  function automatic ent_t with_inst(ent_t e, logic [31:0] rdata);
    ent_t r = e;
    r.inst = e.ex ? 32'h0 : rdata;
    return r;
  endfunction

  function automatic bit model_bypass();
`ifdef INST_QUEUE_BYPASS_EN
    return (mq.size() == 0) && m_s1v && !flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input bit fv, input bit pen, input logic [31:0] pc, input bit ex,
                     input logic [7:0] ec, input bit es, input bit dal, input bit fl);
    FD_valid  = fv;
    FD_BUS    = {pc, pen, ex, ec, es};
    D_allowin = dal;
    flush     = fl;
  endtask

  // Drive read data, settle, then compare the DUT against the model outputs
  task automatic sample();
    bit byp;
    inst_sram_rdata = rd_force_en ? rd_force : (m_s1.pc ^ 32'hA5A5A5A5);
    #1;
    byp     = model_bypass();
    m_allow = flush || (mq.size() + int'(m_s1v) <= DEPTH - 1);
    m_qv    = (mq.size() != 0 && !flush) || byp;
    m_bus   = byp ? pk(with_inst(m_s1, inst_sram_rdata)) : (mq.size() != 0 ? pk(mq[0]) : '0);
    chk("Q_allowin", Q_allowin, m_allow);
    chk("QD_valid", QD_valid, m_qv);
    chk("count", count, mq.size());
    if (m_qv) chk("QD_BUS", QD_BUS, m_bus);
    last_pop    = m_qv && D_allowin;
    last_pop_pc = m_bus[73:42];
  endtask

  // Clock edge: update the model from the inputs held across the edge
  task automatic advance();
    bit byp, acc;
    @(posedge clk);
    byp = model_bypass();
    acc = FD_valid && FD_BUS[10] && m_allow;
    if (flush) mq.delete();
    else begin
      if (mq.size() != 0 && D_allowin) void'(mq.pop_front());
      if (m_s1v && !(byp && D_allowin)) mq.push_back(with_inst(m_s1, inst_sram_rdata));
    end
    m_s1v = acc;
    if (acc) begin
      m_s1.pc    = FD_BUS[42:11];
      m_s1.inst  = '0;
      m_s1.ex    = FD_BUS[9];
      m_s1.ecode = FD_BUS[8:1];
      m_s1.esub  = FD_BUS[0];
    end
    @(negedge clk);
  endtask

  task automatic clean();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    sample();
    advance();
  endtask

  // ---------------- table of streaming vectors ----------------
  typedef struct {
    logic [31:0] pc;
    bit          e_allow;
    bit          e_qv;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] pc, exp_pc;
    int sent, got;
    bit found;

    for (int i = 0; i < 8; i++) begin
      tbl[i].pc      = 32'h1c000000 + 32'(4 * i);
      tbl[i].e_allow = 1'b1;
`ifdef INST_QUEUE_BYPASS_EN
      tbl[i].e_qv  = (i >= 1);
      tbl[i].e_pc  = 32'h1c000000 + 32'(4 * (i - 1));
      tbl[i].e_cnt = 0;
`else
      tbl[i].e_qv  = (i >= 2);
      tbl[i].e_pc  = 32'h1c000000 + 32'(4 * (i - 2));
      tbl[i].e_cnt = (i >= 2) ? 1 : 0;
`endif
    end

    m_s1  = '{default: '0};
    m_s1v = 0;
    rstn  = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    inst_sram_rdata = '0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_QD_valid", QD_valid, 0);
    chk("rst_Q_allowin", Q_allowin, 1);
    chk("rst_count", count, 0);
    chk("rst_QD_BUS", QD_BUS, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Streaming table: the first entry is pc 0x1c000000 with inst 0xB9A5A5A5
    for (int i = 0; i < 8; i++) begin
      drv(1, 1, tbl[i].pc, 0, 0, 0, 1, 0);
      sample();
      chk("tbl_allow", Q_allowin, tbl[i].e_allow);
      chk("tbl_qv", QD_valid, tbl[i].e_qv);
      chk("tbl_cnt", count, tbl[i].e_cnt);
      if (tbl[i].e_qv) begin
        chk("tbl_pc", QD_BUS[73:42], tbl[i].e_pc);
        chk("tbl_inst", QD_BUS[41:10], tbl[i].e_pc ^ 32'hA5A5A5A5);
      end
      advance();
    end
    clean();

    // Decode stall: the FIFO fills to DEPTH, then drains in pc order
    pc = 32'h1c000040;
    for (int c = 0; c < 8; c++) begin
      drv(1, 1, pc, 0, 0, 0, 0, 0);
      sample();
      if (m_allow) pc += 4;
      advance();
    end
    drv(1, 1, pc, 0, 0, 0, 0, 0);
    sample();
    chk("stall_count", count, DEPTH);
    chk("stall_allow", Q_allowin, 0);
    exp_pc = 32'h1c000040;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 0);
      sample();
      if (last_pop) begin chk("stall_order", last_pop_pc, exp_pc); exp_pc += 4; got++; end
      advance();
    end
    chk("stall_pops", got, DEPTH);
    clean();

    // Wrap-around: 10 entries with alternating Decode readiness
    pc = 32'h1c000200; exp_pc = pc; sent = 0; got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      drv(sent < 10, 1, pc, 0, 0, 0, (c % 2) == 1, 0);
      sample();
      if (sent < 10 && m_allow) begin sent++; pc += 4; end
      if (last_pop) begin chk("wrap_order", last_pop_pc, exp_pc); exp_pc += 4; got++; end
      advance();
    end
    chk("wrap_pops", got, 10);
    clean();

    // Flush with count=3 and S1 valid, together with the redirect request
    pc = 32'h1c000080; found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      drv(1, 1, pc, 0, 0, 0, 0, 0);
      sample();
      if (mq.size() == 3 && m_s1v) found = 1;
      else begin
        if (m_allow) pc += 4;
        advance();
      end
    end
    chk("flush_setup", found, 1);
    drv(1, 1, 32'h1c000100, 0, 0, 0, 0, 1);
    sample();
    chk("flush_qv", QD_valid, 0);
    chk("flush_allow", Q_allowin, 1);
    advance();
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("flush_count", count, 0);
    got = 0;
    for (int c = 0; c < 5; c++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 0);
      if (c > 0) sample();
      if (last_pop) begin chk("flush_pc", last_pop_pc, 32'h1c000100); got++; end
      advance();
      last_pop = 0;
    end
    chk("flush_pops", got, 1);
    clean();

    // Exception entry: read data is ignored and inst becomes zero
    drv(1, 1, 32'h1c000002, 1, 8'h08, 0, 0, 0);
    sample();
    advance();
    rd_force_en = 1; rd_force = 32'hFFFFFFFF;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("ex_qv", QD_valid, 1);
    chk("ex_bus", QD_BUS, {32'h1c000002, 32'h0, 1'b1, 8'h08, 1'b0});
    advance();
    clean();

    // Randomized traffic against the model
    pc = 32'h1c001000;
    for (int c = 0; c < 400; c++) begin
      bit fv, pen;
      fv  = ($urandom % 4) != 0;
      pen = ($urandom % 8) != 0;
      rd_force = $urandom;
      drv(fv, pen, pc, ($urandom % 8) == 0, 8'($urandom), 1'($urandom),
          ($urandom % 3) != 0, ($urandom % 16) == 0);
      sample();
      if (fv && pen && m_allow) pc += 4;
      advance();
    end
    rd_force_en = 0;
    clean();

    // Async reset dropped mid-stream between clock edges
    pc = 32'h1c002000;
    for (int c = 0; c < 3; c++) begin
      drv(1, 1, pc, 0, 0, 0, 0, 0);
      sample();
      if (m_allow) pc += 4;
      advance();
    end
    #2 rstn = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("arst_qv", QD_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_allow", Q_allowin, 1);
    mq.delete(); m_s1v = 0; m_s1 = '{default: '0};
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      drv(1, 1, 32'h1c003000 + 32'(4 * c), 0, 0, 0, 1, 0);
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Sits between Fetch and Decode.
- Registers each accepted Fetch request (pc, exception info) for one cycle, so it lines up with the synchronous inst_sram read data that returns the following cycle.
- Pushes the combined entry into a small instruction FIFO.
- Presents the FIFO head to Decode with a valid/allowin handshake. Drives Fetch's D_allowin as backpressure and discards all queued and in-flight work on a pipeline flush.

Parameters:
- DEPTH, 4: FIFO entry count; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter and the count output.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rstn  in  1  reset, asynchronous and active-low; all state cleared immediately on assertion.
- flush  in  1  OR of taken branch, exception entry and ertn; discards queue and in-flight capture.
- FD_valid  in  1  Fetch output valid.
- FD_BUS  in  43  {pc[42:11], pc_en[10], ex[9], ecode[8:1], esubcode[0]}.
- inst_sram_rdata  in  32  instruction word for the request issued in the previous cycle.
- Q_allowin  out  1  to Fetch D_allowin.
- D_allowin  in  1  Decode ready.
- QD_valid  out  1  head entry valid.
- QD_BUS  out  74  {pc[73:42], inst[41:10], ex[9], ecode[8:1], esubcode[0]}.
- count  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (async, rstn=0):
  - s1_valid=0; rd_ptr=wr_ptr=0; count=0.
  - QD_valid=0, Q_allowin=1.
  - QD_BUS is don't-care but is driven from zeroed storage.
- Accept: accept = FD_valid && FD_BUS[10] && Q_allowin. On accept, the S1 register loads FD_BUS fields and s1_valid is set to 1. Otherwise s1_valid is set to 0.
- Push: when s1_valid=1, the entry {s1_pc, inst, s1_ex, s1_ecode, s1_esubcode} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - inst = inst_sram_rdata when s1_ex=0.
  - inst = 32'h0 when s1_ex=1, because ADEF requests return no valid data.
- Pop:
  - QD_valid = (count!=0) && !flush.
  - QD_BUS = storage[rd_ptr], driven combinationally.
  - pop = QD_valid && D_allowin; rd_ptr increments modulo DEPTH.
- Count: count_next = count + push - pop. A simultaneous push and pop leaves count unchanged.
- Backpressure: Q_allowin = flush || (count + s1_valid <= DEPTH-1). This term does not depend on D_allowin, so there is no combinational path from Decode to Fetch. Overflow is impossible by construction; the bench checks this with an assertion.
- Full: with count=DEPTH, Q_allowin=0 until a pop occurs. With count=DEPTH-1 and s1_valid=1, Q_allowin=0.
- Empty: QD_valid=0. A pop never occurs.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count alone distinguishes full from empty.
- Flush cycle:
  - Next state: count=0, rd_ptr=wr_ptr=0, and S1 contents are discarded with no push.
  - Q_allowin=1 and QD_valid=0 in the flush cycle.
  - A Fetch request in the same cycle (the redirect target) is accepted into S1, so the redirect is not lost.
- Flush and accept together: the new request survives. Only older work is dropped.
- Reset mid-operation: all entries and the S1 capture are lost immediately. No partial push occurs.
- Latency without bypass:
  - Request accepted at cycle T, S1 valid at T+1, push at end of T+1, QD_valid=1 at T+2.
  - Steady-state throughput is 1 instruction/cycle when DEPTH>=3 and Decode is always ready.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- When defined:
  - If count=0, s1_valid=1 and flush=0, then QD_valid=1 and QD_BUS = the S1 entry with its inst (as defined under Push), at cycle T+1.
  - If D_allowin=1 that cycle, the entry is consumed and not pushed. Otherwise it is pushed normally.
  - Q_allowin is unchanged.
- When undefined: no bypass path; latency is exactly 2 cycles as specified under Behaviour.

Test Plan:
- Reset then stream: FD_valid=1, pc_en=1, pc=0x1c000000,+4,..., D_allowin=1, rdata=pc^0xA5A5A5A5 -> first QD_valid at cycle 2 (cycle 1 with bypass), pc 0x1c000000 with inst 0xB9A5A5A5, then one per cycle in order, count<=2.
- Decode stall: D_allowin=0, continuous requests, DEPTH=4 -> count reaches 4, Q_allowin=0 from the cycle count+s1_valid=4, no entry lost or overwritten. On release, entries drain in pc order with 4 pops.
- Wrap-around: push/pop 10 entries with alternating D_allowin -> pointers wrap twice, output pc sequence strictly increments by 4.
- Flush with pending: count=3, s1_valid=1, flush=1 together with request pc=0x1c000100 -> QD_valid=0 in flush cycle, count=0 next cycle, next QD_BUS pc=0x1c000100 only.
- Exception entry: FD_BUS ex=1, ecode=0x08, pc=0x1c000002, rdata=0xFFFFFFFF -> QD_BUS inst=0, ex=1, ecode=0x08, esubcode=0.
- Async reset: rstn dropped mid-stream between clock edges -> QD_valid=0, count=0 immediately, Q_allowin=1.
